// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: retire qualification, RF write port, counters, halt detect.
// Optional one-entry bypass register enabled by defining WB_BYPASS_EN.
module wb_retire_stage #(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] HALT_I0 = 32'h00c00093,
    parameter logic [31:0] HALT_I1 = 32'h00008067
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             MEM_WB_update,
    input  logic             nop_WB,
    input  logic             stall_nop_WB,
    input  logic             is_jmp_WB,
    input  logic             is_taken_WB,
    input  logic [31:0]      inst_WB,
    input  logic [31:0]      Mem_RD_WB,
    input  logic [31:0]      ALU_Result_WB,
    input  logic [4:0]       RegDest_WB,
    input  logic             MemtoReg_WB,
    input  logic             RegWrite_WB,
    output logic             RF_WE,
    output logic [4:0]       RF_WA,
    output logic [31:0]      RF_WD,
    output logic [CNT_W-1:0] NUM_INST,
    output logic [CNT_W-1:0] NUM_TAKEN,
    output logic             HALT,
    output logic             BYP_VALID,
    output logic [4:0]       BYP_ADDR,
    output logic [31:0]      BYP_DATA
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_SEEN0  = 2'd1,
        S_HALTED = 2'd2
    } halt_state_t;

    halt_state_t state, state_nxt;

    logic        halted;
    logic        retire;
    logic        we;
    logic [31:0] wd;

    assign halted = (state == S_HALTED);
    assign retire = MEM_WB_update & ~nop_WB & ~stall_nop_WB & ~halted;
    assign wd     = MemtoReg_WB ? Mem_RD_WB : ALU_Result_WB;
    assign we     = retire & RegWrite_WB & (RegDest_WB != 5'd0);
    assign HALT   = halted;

    // Sequence detector only advances on retiring entries, so bubbles are transparent.
    always_comb begin
        state_nxt = state;
        if (retire) begin
            unique case (state)
                S_RUN: begin
                    if (inst_WB == HALT_I0)
                        state_nxt = S_SEEN0;
                end
                S_SEEN0: begin
                    if (inst_WB == HALT_I1)
                        state_nxt = S_HALTED;
                    else if (inst_WB == HALT_I0)
                        state_nxt = S_SEEN0;
                    else
                        state_nxt = S_RUN;
                end
                S_HALTED: state_nxt = S_HALTED;
                default:  state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            RF_WE <= 1'b0;
            RF_WA <= 5'd0;
            RF_WD <= 32'd0;
        end else begin
            RF_WE <= we;
            RF_WA <= RegDest_WB;
            RF_WD <= wd;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            NUM_INST  <= '0;
            NUM_TAKEN <= '0;
        end else if (retire) begin
            NUM_INST <= NUM_INST + CNT_W'(1);
            if (is_jmp_WB | is_taken_WB)
                NUM_TAKEN <= NUM_TAKEN + CNT_W'(1);
        end
    end

`ifdef WB_BYPASS_EN
    // Holds the write just presented to the RF to cover the read-during-write window.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            BYP_VALID <= 1'b0;
            BYP_ADDR  <= 5'd0;
            BYP_DATA  <= 32'd0;
        end else begin
            BYP_VALID <= RF_WE;
            BYP_ADDR  <= RF_WA;
            BYP_DATA  <= RF_WD;
        end
    end
`else
    assign BYP_VALID = 1'b0;
    assign BYP_ADDR  = 5'd0;
    assign BYP_DATA  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Self-checking bench for wb_retire_stage: directed scenarios plus
// randomized traffic against a behavioural retire/halt model.
module tb_wb_retire_stage;

    localparam logic [31:0] I0 = 32'h00c00093;
    localparam logic [31:0] I1 = 32'h00008067;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        MEM_WB_update = 1'b0;
    logic        nop_WB = 1'b0;
    logic        stall_nop_WB = 1'b0;
    logic        is_jmp_WB = 1'b0;
    logic        is_taken_WB = 1'b0;
    logic [31:0] inst_WB = '0;
    logic [31:0] Mem_RD_WB = '0;
    logic [31:0] ALU_Result_WB = '0;
    logic [4:0]  RegDest_WB = '0;
    logic        MemtoReg_WB = 1'b0;
    logic        RegWrite_WB = 1'b0;
    logic        RF_WE;
    logic [4:0]  RF_WA;
    logic [31:0] RF_WD;
    logic [31:0] NUM_INST;
    logic [31:0] NUM_TAKEN;
    logic        HALT;
    logic        BYP_VALID;
    logic [4:0]  BYP_ADDR;
    logic [31:0] BYP_DATA;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic        m_we, m_bv;
    logic [4:0]  m_wa, m_ba;
    logic [31:0] m_wd, m_bd;
    int unsigned m_inst, m_taken;
    bit          m_halt, m_prev_i0;

    wb_retire_stage dut (
        .CLK(CLK), .RSTn(RSTn),
        .MEM_WB_update(MEM_WB_update),
        .nop_WB(nop_WB), .stall_nop_WB(stall_nop_WB),
        .is_jmp_WB(is_jmp_WB), .is_taken_WB(is_taken_WB),
        .inst_WB(inst_WB), .Mem_RD_WB(Mem_RD_WB),
        .ALU_Result_WB(ALU_Result_WB), .RegDest_WB(RegDest_WB),
        .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
        .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD),
        .NUM_INST(NUM_INST), .NUM_TAKEN(NUM_TAKEN), .HALT(HALT),
        .BYP_VALID(BYP_VALID), .BYP_ADDR(BYP_ADDR), .BYP_DATA(BYP_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_we = 0; m_wa = 0; m_wd = 0;
        m_bv = 0; m_ba = 0; m_bd = 0;
        m_inst = 0; m_taken = 0;
        m_halt = 0; m_prev_i0 = 0;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;
    endtask

    // Apply one MEM/WB entry, advance the model, take an edge, settle.
    task automatic cycle(input bit v, input bit n, input bit s,
                         input bit j, input bit t, input logic [31:0] ins,
                         input logic [31:0] md, input logic [31:0] alu,
                         input logic [4:0] rd, input bit m2r, input bit rw);
        bit ret;
        MEM_WB_update = v; nop_WB = n; stall_nop_WB = s;
        is_jmp_WB = j; is_taken_WB = t; inst_WB = ins;
        Mem_RD_WB = md; ALU_Result_WB = alu; RegDest_WB = rd;
        MemtoReg_WB = m2r; RegWrite_WB = rw;
`ifdef WB_BYPASS_EN
        m_bv = m_we; m_ba = m_wa; m_bd = m_wd;
`endif
        ret  = v && !n && !s && !m_halt;
        m_we = ret && rw && (rd != 0);
        m_wa = rd;
        m_wd = m2r ? md : alu;
        if (ret) begin
            m_inst++;
            if (j || t) m_taken++;
            if (m_prev_i0 && ins == I1) m_halt = 1;
            m_prev_i0 = (ins == I0);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if ({RF_WE, RF_WA, RF_WD, NUM_INST, NUM_TAKEN, HALT} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h inst=%0d taken=%0d halt=%b, want all 0",
                     RF_WE, RF_WA, RF_WD, NUM_INST, NUM_TAKEN, HALT);
        end
        n_checks++;
        if ({BYP_VALID, BYP_ADDR, BYP_DATA} !== '0) begin
            n_errors++;
            $display("FAIL reset_bypass: got %b/%0d/%h want 0", BYP_VALID, BYP_ADDR, BYP_DATA);
        end
        do_reset();
    endtask

    task automatic test_alu_and_load();
        do_reset();
        cycle(1, 0, 0, 0, 0, 32'h13, 32'h0, 32'h1234, 5'd5, 0, 1);
        n_checks++;
        if (RF_WE !== 1'b1 || RF_WA !== 5'd5 || RF_WD !== 32'h1234) begin
            n_errors++;
            $display("FAIL alu_write: got we=%b wa=%0d wd=%h want 1/5/00001234", RF_WE, RF_WA, RF_WD);
        end
        n_checks++;
        if (NUM_INST !== 32'd1) begin
            n_errors++;
            $display("FAIL alu_count: got %0d want 1", NUM_INST);
        end
        cycle(1, 0, 0, 0, 0, 32'h3, 32'hDEADBEEF, 32'h55, 5'd0, 1, 1);
        n_checks++;
        if (RF_WE !== 1'b0 || RF_WD !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL load_x0: got we=%b wd=%h want 0/deadbeef", RF_WE, RF_WD);
        end
        n_checks++;
        if (NUM_INST !== 32'd2) begin
            n_errors++;
            $display("FAIL load_x0_count: got %0d want 2", NUM_INST);
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        cycle(1, 0, 0, 1, 0, 32'h13, 32'h0, 32'h1, 5'd4, 0, 1);
        cycle(1, 1, 0, 1, 1, 32'h13, 32'h0, 32'h2, 5'd7, 0, 1);
        n_checks++;
        if (RF_WE !== 1'b0 || RF_WA !== 5'd7 || NUM_INST !== 32'd1 || NUM_TAKEN !== 32'd1) begin
            n_errors++;
            $display("FAIL nop_bubble: got we=%b wa=%0d inst=%0d taken=%0d want 0/7/1/1",
                     RF_WE, RF_WA, NUM_INST, NUM_TAKEN);
        end
        cycle(1, 0, 1, 0, 1, 32'h13, 32'h0, 32'h3, 5'd8, 0, 1);
        n_checks++;
        if (RF_WE !== 1'b0 || NUM_INST !== 32'd1 || NUM_TAKEN !== 32'd1) begin
            n_errors++;
            $display("FAIL stall_bubble: got we=%b inst=%0d taken=%0d want 0/1/1",
                     RF_WE, NUM_INST, NUM_TAKEN);
        end
    endtask

    task automatic test_halt();
        do_reset();
        cycle(1, 0, 0, 0, 0, I0, 32'h0, 32'hC, 5'd1, 0, 1);
        n_checks++;
        if (RF_WE !== 1'b1 || RF_WA !== 5'd1 || RF_WD !== 32'hC || HALT !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_x1_write: got we=%b wa=%0d wd=%h halt=%b want 1/1/c/0",
                     RF_WE, RF_WA, RF_WD, HALT);
        end
        cycle(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);
        cycle(1, 0, 0, 1, 0, I1, 32'h0, 32'h0, 5'd0, 0, 0);
        n_checks++;
        if (HALT !== 1'b1 || NUM_INST !== 32'd2) begin
            n_errors++;
            $display("FAIL halt_seq: got halt=%b inst=%0d want 1/2", HALT, NUM_INST);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 1, 1, 32'h13, 32'h0, 32'h99, 5'd3, 0, 1);
            n_checks++;
            if (RF_WE !== 1'b0 || NUM_INST !== 32'd2 || NUM_TAKEN !== 32'd1 || HALT !== 1'b1) begin
                n_errors++;
                $display("FAIL halt_frozen: got we=%b inst=%0d taken=%0d halt=%b want 0/2/1/1",
                         RF_WE, NUM_INST, NUM_TAKEN, HALT);
            end
        end
    endtask

    task automatic test_halt_broken();
        do_reset();
        cycle(1, 0, 0, 0, 0, I0, 32'h0, 32'h0, 5'd1, 0, 1);
        cycle(1, 0, 0, 0, 0, 32'h13, 32'h0, 32'h0, 5'd0, 0, 1);
        cycle(1, 0, 0, 0, 0, I1, 32'h0, 32'h0, 5'd0, 0, 0);
        n_checks++;
        if (HALT !== 1'b0 || NUM_INST !== 32'd3) begin
            n_errors++;
            $display("FAIL halt_broken: got halt=%b inst=%0d want 0/3", HALT, NUM_INST);
        end
        cycle(1, 0, 0, 0, 0, I0, 32'h0, 32'h0, 5'd1, 0, 1);
        cycle(1, 0, 0, 0, 0, I0, 32'h0, 32'h0, 5'd1, 0, 1);
        cycle(1, 0, 0, 0, 0, I1, 32'h0, 32'h0, 5'd1, 0, 1);
        n_checks++;
        if (HALT !== 1'b1 || RF_WE !== 1'b1 || NUM_INST !== 32'd6) begin
            n_errors++;
            $display("FAIL halt_repeat_i0: got halt=%b we=%b inst=%0d want 1/1/6", HALT, RF_WE, NUM_INST);
        end
    endtask

    task automatic test_taken_reset();
        logic [37:0] want_byp;
        do_reset();
        cycle(1, 0, 0, 0, 1, 32'h63, 32'h0, 32'hA, 5'd2, 0, 1);
        cycle(1, 0, 0, 1, 0, 32'h6f, 32'h0, 32'hB, 5'd3, 0, 1);
`ifdef WB_BYPASS_EN
        want_byp = {1'b1, 5'd2, 32'hA};
`else
        want_byp = '0;
`endif
        n_checks++;
        if ({BYP_VALID, BYP_ADDR, BYP_DATA} !== want_byp) begin
            n_errors++;
            $display("FAIL bypass_trail: got %b/%0d/%h want %h", BYP_VALID, BYP_ADDR, BYP_DATA, want_byp);
        end
        cycle(1, 0, 0, 0, 0, 32'h13, 32'h0, 32'hC, 5'd4, 0, 1);
        n_checks++;
        if (NUM_TAKEN !== 32'd2 || NUM_INST !== 32'd3) begin
            n_errors++;
            $display("FAIL taken_count: got taken=%0d inst=%0d want 2/3", NUM_TAKEN, NUM_INST);
        end
        #2 RSTn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({RF_WE, RF_WA, RF_WD, NUM_INST, NUM_TAKEN, HALT, BYP_VALID, BYP_ADDR, BYP_DATA} !== '0) begin
            n_errors++;
            $display("FAIL midstream_reset: got we=%b inst=%0d taken=%0d byp=%b want all 0",
                     RF_WE, NUM_INST, NUM_TAKEN, BYP_VALID);
        end
        @(posedge CLK);
        #1 RSTn = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int          sel;
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 0) do_reset();
            sel = $urandom_range(0, 9);
            ins = (sel < 2) ? I0 : (sel < 4) ? I1 : $urandom;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, ins, $urandom, $urandom,
                  5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0);
            n_checks++;
            if ({RF_WE, RF_WA, RF_WD} !== {m_we, m_wa, m_wd}) begin
                n_errors++;
                $display("FAIL rand_rf[%0d]: got %b/%0d/%h want %b/%0d/%h",
                         i, RF_WE, RF_WA, RF_WD, m_we, m_wa, m_wd);
            end
            n_checks++;
            if (NUM_INST !== m_inst || NUM_TAKEN !== m_taken || HALT !== m_halt) begin
                n_errors++;
                $display("FAIL rand_state[%0d]: got inst=%0d taken=%0d halt=%b want %0d/%0d/%b",
                         i, NUM_INST, NUM_TAKEN, HALT, m_inst, m_taken, m_halt);
            end
            n_checks++;
            if ({BYP_VALID, BYP_ADDR, BYP_DATA} !== {m_bv, m_ba, m_bd}) begin
                n_errors++;
                $display("FAIL rand_byp[%0d]: got %b/%0d/%h want %b/%0d/%h",
                         i, BYP_VALID, BYP_ADDR, BYP_DATA, m_bv, m_ba, m_bd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_and_load();
        test_bubbles();
        test_halt();
        test_halt_broken();
        test_taken_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
